tone_player: RTL and testbench
==============================

# tone_player

Timed square-wave tone generator for the DE0-Nano-SoC speaker output, driven by the Simon game controller. It accepts a note index (1–9, C4 to D5) and a duration in milliseconds through a start/busy/done handshake. It plays the note for that duration, optionally follows it with a silent gap, then pulses `done`. Clock frequency, index width, duration width and gap length are parameters.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency in Hz.
- `NUM_W`, 4: width of the note index.
- `DUR_W`, 12: width of the duration field, in ms (maximum 4095 ms).
- `GAP_MS`, 0: silent gap after each note before `done`; 0 means no gap state.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request pulse; sampled only in IDLE.
- `num`  in  NUM_W: note index, sampled with `start`.
- `dur_ms`  in  DUR_W: note duration in ms, sampled with `start`.
- `abort`  in  1: stop immediately and return to IDLE.
- `busy`  out  1: high while in PLAY or GAP.
- `done`  out  1: one-cycle pulse when a note and its gap complete.
- `spkr`  out  1: square-wave speaker drive.
- `freq_hz`  out  32: nominal frequency of the latched note (0 for a rest), for display.

## Operation
- Note table (Hz) for indices 1..9: 262, 294, 330, 350, 392, 440, 494, 523, 587.
- Any other index (0, or 10 and above) is a rest: `spkr` stays low, but the duration is still timed.
- Half-period count: HALF = round(CLK_HZ / (2·f)). Example: at 50 MHz, A (440 Hz) gives HALF = 56818.
- The half-period counter must be wide enough for the lowest note: 17 bits at 50 MHz.
- A ms tick fires once every CLK_HZ/1000 clocks. Its counter is cleared when `start` is accepted, so each note's ms timing starts from zero.

State machine:
- IDLE: on `start` with `abort` low, latch `num`, `dur_ms` and HALF.
  - If `dur_ms` = 0 and `GAP_MS` = 0: stay in IDLE and pulse `done` on the next cycle.
  - If `dur_ms` = 0 and `GAP_MS` > 0: go to GAP.
  - Otherwise: go to PLAY.
- PLAY: `spkr` toggles every HALF clocks. The ms counter counts down from `dur_ms`. When it reaches 0, go to GAP (if `GAP_MS` > 0) or to IDLE with `done`.
- GAP: `spkr` is low. Count `GAP_MS` ticks, then go to IDLE with `done`.
- `abort` in any state: go to IDLE next cycle, `spkr` low, no `done`. `abort` has priority over a simultaneous `start`.
- `start` while `busy` is ignored. There is no queueing and no retrigger.
- `freq_hz` holds the latched note's value until the next accepted `start`. It resets to 0.

## Timing
- Reset values: state IDLE, and `busy`, `done`, `spkr`, `freq_hz` all 0. All counters clear.
- Let `start` be accepted on the rising edge of cycle N.
- `busy` goes high in cycle N+1.
- `spkr` goes high in cycle N+1 (non-rest notes) and first toggles in cycle N+1+HALF.
- PLAY lasts exactly `dur_ms`·(CLK_HZ/1000) cycles. GAP lasts exactly `GAP_MS`·(CLK_HZ/1000) cycles.
- In the cycle `done` is high, `busy` is already low and `spkr` is low. `spkr` is forced low when leaving PLAY, whatever its phase.
- The earliest restart is a `start` asserted in the same cycle as `done`; it is accepted.
- Reset asserted mid-note behaves as an abort, plus `freq_hz` clears.

## Structure
- Package `tone_pkg` holds:
  - `NOTE_HZ[1:9]` constant array;
  - `half_count(clk_hz, hz)` constant function;
  - state enum `tone_state_t` {IDLE, PLAY, GAP}.
- The half-period table is computed at elaboration from `CLK_HZ`. There are no runtime dividers.
- Sub-module `ms_tick` is a parametrised prescaler with a synchronous clear input and a one-cycle `tick` output.

## Test plan
Bench parameters: CLK_HZ = 100_000 (1 ms = 100 cycles), DUR_W = 12.
- `num`=6, `dur_ms`=3, GAP_MS=0:
  - HALF = 114; `spkr` toggles at N+1, N+115, N+229;
  - `busy` is high for 300 cycles;
  - `done` is a single pulse at N+301;
  - `freq_hz` = 440.
- `num`=0, `dur_ms`=2 (rest): `spkr` stays low throughout; `busy` is high for 200 cycles; `done` pulses once; `freq_hz` = 0.
- GAP_MS=1, `num`=1, `dur_ms`=1: 100 cycles of tone (HALF = 191), then 100 cycles with `spkr` low and `busy` high, then `done`.
- `abort` at N+50 during `num`=8: `busy` and `spkr` low at N+51; no `done` within the next 500 cycles. A simultaneous `start`+`abort` in IDLE is not accepted.
- `start` asserted while busy: ignored, and the current note timing is unchanged. `start` in the `done` cycle is accepted, with `busy` high on the next cycle.
- `dur_ms`=0 with GAP_MS=0: `done` at N+1 and `busy` never rises. Reset asserted mid-note: all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants and types for the Simon speaker tone player:
// note table, half-period helper and the player state encoding.
package tone_pkg;

  localparam int NOTE_HZ [1:9] = '{262, 294, 330, 350, 392, 440, 494, 523, 587};

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } tone_state_t;

  // Rounded clk_hz / (2*hz), kept in integer arithmetic so it folds at elaboration.
  function automatic int half_count(input int clk_hz, input int hz);
    return (clk_hz + hz) / (2 * hz);
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: tick is high for one cycle every DIV clocks,
// and clear restarts the count so the next tick lands DIV cycles later.
module ms_tick #(
  parameter int DIV = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tone_player.sv
// Timed square-wave tone generator with start/busy/done handshake, an
// optional silent gap after each note and an abort that never yields done.
module tone_player
  import tone_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int NUM_W  = 4,
  parameter int DUR_W  = 12,
  parameter int GAP_MS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DUR_W-1:0] dur_ms,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             spkr,
  output logic [31:0]      freq_hz
);

  localparam int MS_DIV   = CLK_HZ / 1000;
  localparam int HALF_MAX = half_count(CLK_HZ, NOTE_HZ[1]);
  localparam int HALF_W   = $clog2(HALF_MAX + 1);

  typedef logic [9:1][HALF_W-1:0] half_tab_t;

  function automatic half_tab_t build_half_tab();
    half_tab_t t;
    for (int i = 1; i <= 9; i++) begin
      t[i] = HALF_W'(half_count(CLK_HZ, NOTE_HZ[i]));
    end
    return t;
  endfunction

  localparam half_tab_t HALF_TAB = build_half_tab();

  tone_state_t       state;
  logic              tick;
  logic              accept;
  logic              is_note;
  logic              tone_on;
  logic [HALF_W-1:0] half_sel;
  logic [HALF_W-1:0] half_val;
  logic [HALF_W-1:0] half_cnt;
  logic [31:0]       freq_sel;
  logic [DUR_W-1:0]  ms_left;

  assign accept = (state == IDLE) && start && !abort;

  // Indices outside 1..9 fall through as rests with no half period and 0 Hz.
  always_comb begin
    is_note  = 1'b0;
    half_sel = '0;
    freq_sel = '0;
    for (int i = 1; i <= 9; i++) begin
      if (num == NUM_W'(i)) begin
        is_note  = 1'b1;
        half_sel = HALF_TAB[i];
        freq_sel = 32'(NOTE_HZ[i]);
      end
    end
  end

  ms_tick #(
    .DIV(MS_DIV)
  ) u_ms_tick (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      spkr     <= 1'b0;
      freq_hz  <= '0;
      tone_on  <= 1'b0;
      half_val <= '0;
      half_cnt <= '0;
      ms_left  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        spkr  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              freq_hz  <= freq_sel;
              half_val <= half_sel;
              half_cnt <= '0;
              tone_on  <= is_note;
              ms_left  <= dur_ms;
              if (dur_ms == '0) begin
                if (GAP_MS == 0) begin
                  done <= 1'b1;
                end else begin
                  state   <= GAP;
                  busy    <= 1'b1;
                  ms_left <= DUR_W'(GAP_MS);
                end
              end else begin
                state <= PLAY;
                busy  <= 1'b1;
                spkr  <= is_note;
              end
            end
          end

          PLAY: begin
            if (tone_on) begin
              if (half_cnt == half_val - 1'b1) begin
                half_cnt <= '0;
                spkr     <= ~spkr;
              end else begin
                half_cnt <= half_cnt + 1'b1;
              end
            end
            // Leaving PLAY overrides any toggle so the speaker always ends low.
            if (tick) begin
              if (ms_left == DUR_W'(1)) begin
                spkr <= 1'b0;
                if (GAP_MS > 0) begin
                  state   <= GAP;
                  ms_left <= DUR_W'(GAP_MS);
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end else begin
                ms_left <= ms_left - 1'b1;
              end
            end
          end

          GAP: begin
            spkr <= 1'b0;
            if (tick) begin
              if (ms_left == DUR_W'(1)) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                ms_left <= ms_left - 1'b1;
              end
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            spkr  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_player.sv
// Bench for tone_player at 100 kHz (1 ms = 100 cycles), one instance without
// and one with a 1 ms gap, compared cycle by cycle against a waveform model.
module tb_tone_player;

  localparam int CLK_HZ = 100_000;
  localparam int P      = CLK_HZ / 1000;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        abort  = 1'b0;
  logic [3:0]  num    = '0;
  logic [11:0] dur_ms = '0;
  logic        busy0, done0, spkr0;
  logic        busy1, done1, spkr1;
  logic [31:0] freq0, freq1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tone_player #(
    .CLK_HZ(CLK_HZ), .NUM_W(4), .DUR_W(12), .GAP_MS(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start0), .num(num), .dur_ms(dur_ms),
    .abort(abort), .busy(busy0), .done(done0), .spkr(spkr0), .freq_hz(freq0)
  );

  tone_player #(
    .CLK_HZ(CLK_HZ), .NUM_W(4), .DUR_W(12), .GAP_MS(1)
  ) dut_gap (
    .clk(clk), .reset(reset), .start(start1), .num(num), .dur_ms(dur_ms),
    .abort(abort), .busy(busy1), .done(done1), .spkr(spkr1), .freq_hz(freq1)
  );

  function automatic int note_hz(input int n);
    case (n)
      1: return 262;
      2: return 294;
      3: return 330;
      4: return 350;
      5: return 392;
      6: return 440;
      7: return 494;
      8: return 523;
      9: return 587;
      default: return 0;
    endcase
  endfunction

  function automatic int half_of(input int n);
    return $rtoi(real'(CLK_HZ) / (2.0 * real'(note_hz(n))) + 0.5);
  endfunction

  task automatic applyStimulus(input bit g, input int n, input int d);
    @(posedge clk);
    #1;
    num    = 4'(n);
    dur_ms = 12'(d);
    if (g) start1 = 1'b1;
    else   start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Called in cycle N+1 of an accepted note; checks cycles N+1..N+kmax.
  task automatic check_trace(input bit g, input int n, input int d, input int kmax,
                             input int inj_k, input string tag);
    int gap_ms, play_len, total, h;
    logic eb, ed, es, b, dn, s;
    logic [31:0] f;
    gap_ms   = g ? 1 : 0;
    play_len = d * P;
    total    = (d + gap_ms) * P;
    h        = (note_hz(n) != 0) ? half_of(n) : 1;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      b  = g ? busy1 : busy0;
      dn = g ? done1 : done0;
      s  = g ? spkr1 : spkr0;
      f  = g ? freq1 : freq0;
      eb = (k <= total);
      ed = (k == total + 1);
      es = (note_hz(n) != 0) && (k <= play_len) && (((k - 1) / h) % 2 == 0);
      n_checks++;
      if ({b, dn, s} !== {eb, ed, es}) begin
        n_fail++;
        $display("[TB] FAIL %s k=%0d busy/done/spkr got %b%b%b expected %b%b%b",
                 tag, k, b, dn, s, eb, ed, es);
      end
      if (k == 1) begin
        n_checks++;
        if (f !== 32'(note_hz(n))) begin
          n_fail++;
          $display("[TB] FAIL %s freq_hz got %0d expected %0d", tag, f, note_hz(n));
        end
      end
      if (inj_k != 0 && k == inj_k) begin
        num    = 4'd1;
        dur_ms = 12'd1;
        if (g) start1 = 1'b1;
        else   start0 = 1'b1;
      end else if (inj_k != 0 && k == inj_k + 1) begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy0, done0, spkr0, freq0} !== 35'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_plain outputs got %b%b%b/%0d expected 000/0", busy0, done0, spkr0, freq0);
    end
    n_checks++;
    if ({busy1, done1, spkr1, freq1} !== 35'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_gap outputs got %b%b%b/%0d expected 000/0", busy1, done1, spkr1, freq1);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_note_a4();
    applyStimulus(0, 6, 3);
    check_trace(0, 6, 3, 305, 0, "note_a4");
  endtask

  task automatic test_rest();
    applyStimulus(0, 0, 2);
    check_trace(0, 0, 2, 205, 0, "rest");
  endtask

  task automatic test_gap();
    applyStimulus(1, 1, 1);
    check_trace(1, 1, 1, 205, 0, "gap");
  endtask

  task automatic test_zero_dur();
    applyStimulus(0, 5, 0);
    check_trace(0, 5, 0, 5, 0, "zero_dur");
  endtask

  task automatic test_abort();
    int seen;
    applyStimulus(0, 8, 3);
    check_trace(0, 8, 3, 50, 0, "abort_pre");
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy0, spkr0} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL abort_stop busy/spkr got %b%b expected 00", busy0, spkr0);
    end
    seen = 0;
    repeat (500) begin
      @(negedge clk);
      if (done0 !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_done done cycles got %0d expected 0", seen);
    end
    @(posedge clk);
    #1;
    num    = 4'd6;
    dur_ms = 12'd1;
    start0 = 1'b1;
    abort  = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    abort  = 1'b0;
    seen   = 0;
    repeat (150) begin
      @(negedge clk);
      if (busy0 !== 1'b0 || done0 !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("[TB] FAIL start_abort_same active cycles got %0d expected 0", seen);
    end
  endtask

  task automatic test_ignore_start();
    applyStimulus(0, 6, 2);
    check_trace(0, 6, 2, 205, 30, "busy_start");
  endtask

  task automatic test_back_to_back();
    applyStimulus(0, 3, 1);
    check_trace(0, 3, 1, 100, 0, "b2b_first");
    @(negedge clk);
    n_checks++;
    if ({done0, busy0} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL b2b_done done/busy got %b%b expected 10", done0, busy0);
    end
    num    = 4'd9;
    dur_ms = 12'd2;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    check_trace(0, 9, 2, 203, 0, "b2b_second");
  endtask

  task automatic test_random();
    int g, n, d;
    for (int i = 0; i < 6; i++) begin
      g = $urandom_range(0, 1);
      n = $urandom_range(0, 15);
      d = $urandom_range(0, 3);
      applyStimulus(g[0], n, d);
      check_trace(g[0], n, d, (d + g) * P + 3, 0, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(0, 3, 3);
    check_trace(0, 3, 3, 40, 0, "pre_reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if ({busy0, done0, spkr0, freq0} !== 35'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid outputs got %b%b%b/%0d expected 000/0", busy0, done0, spkr0, freq0);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_note_a4();
    test_rest();
    test_gap();
    test_zero_dur();
    test_abort();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
